wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Drives the single write port of the pipelined CPU register file (RDaddr/RDdata/RegWrite), i.e. the writer side of the register-file write interface.
- Merges two result sources into one registered write per cycle:
  - the in-order MEM/WB pipeline result;
  - a long-latency unit (multi-cycle load/multiply) result, buffered in a small FIFO behind a valid/ready handshake.
- Publishes a pending-destination bitmap for the hazard unit.
- Raises a one-cycle stall when buffered results starve.

Parameters:
DEPTH, 4, long-latency result FIFO entries (power of two, >=2)
MAX_WAIT, 8, consecutive non-popped cycles with FIFO non-empty before stall_o asserts (>=1)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_n_i  input  1  asynchronous active-low reset
pipe_valid_i  input  1  MEM/WB result valid this cycle
pipe_addr_i  input  5  MEM/WB destination register
pipe_data_i  input  32  MEM/WB result data
lu_valid_i  input  1  long-latency result valid
lu_ready_o  output  1  FIFO can accept (handshake = lu_valid_i & lu_ready_o at rising edge)
lu_addr_i  input  5  long-latency destination register
lu_data_i  input  32  long-latency result data
RDaddr_o  output  5  register-file write address
RDdata_o  output  32  register-file write data
RegWrite_o  output  1  register-file write enable
pend_o  output  32  bit i = some FIFO entry targets register i
stall_o  output  1  upstream must hold MEM/WB this cycle

Behaviour:
- Reset (rst_n_i low, asynchronous): RegWrite_o=0, RDaddr_o=0, RDdata_o=0, FIFO empty, wait counter 0.
  - Resulting outputs: pend_o=0, stall_o=0, lu_ready_o=0 while reset is asserted.
  - After release: lu_ready_o=1.
  - Reset mid-operation discards all buffered entries and cancels any in-flight write.
- Write outputs are registered.
  - Values granted at rising edge N are held from edge N to edge N+1.
  - They are stable across the register file's falling-edge write.
  - RegWrite_o=0 when nothing is granted; RDaddr_o/RDdata_o then hold their last values.
- Per-cycle grant, evaluated at each rising edge, in priority order:
  1. If stall_o=1: pop FIFO head (forced); pipe_valid_i is ignored.
  2. Else if pipe_valid_i=1 and pipe_addr_i!=0: grant the pipe.
  3. Else if FIFO non-empty: pop the head.
  4. Else: no write.
- Register 0:
  - A pipe result with addr 0 is dropped and never drives RegWrite_o; the FIFO may drain that cycle.
  - A long-latency handshake with addr 0 completes but is not enqueued.
- FIFO:
  - Circular buffer with wrap-around read/write pointers and a count 0..DEPTH.
  - lu_ready_o = (count != DEPTH), derived from registered state only.
  - When full, ready stays low even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged, order preserved.
- Latency:
  - Pipe sample to RegWrite_o: 1 cycle.
  - Long-latency handshake to RegWrite_o: 2 cycles minimum (enqueue, then pop). There is no empty-FIFO bypass.
- pend_o:
  - Combinational OR over valid FIFO entries of the one-hot address.
  - Bit 0 is always 0.
  - Set the cycle after enqueue; cleared the cycle after the pop that removes the last entry for that address.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs; saturates at MAX_WAIT.
  - Clears on any pop or when empty.
  - stall_o = (counter == MAX_WAIT). It lasts exactly one cycle, since the forced pop clears the counter.
- Write ordering:
  - Writes issue in grant order; FIFO entries retire in arrival order.
  - WAW hazards between the two sources are resolved by the hazard unit using pend_o, not here.

Test Plan:
1. Idle after reset; pipe_valid_i=1, addr=5, data=0xDEADBEEF at edge N -> RegWrite_o=1, RDaddr_o=5, RDdata_o=0xDEADBEEF during N..N+1; RegWrite_o=0 after.
2. Pipe idle; LU handshake addr=7, data=0x12345678 at edge N -> pend_o=0x00000080 during N..N+1; write to r7 during N+1..N+2; pend_o=0 after N+1.
3. Pipe valid every cycle (addr 3), four LU pushes (addr 8..11) -> lu_ready_o=0 after 4th push; 5th held; MAX_WAIT=8 -> stall_o high one cycle 8 cycles after first enqueue, r8 written, pipe ignored that cycle, ready returns next cycle.
4. Pipe addr=0 with FIFO holding r9 -> no write to r0; r9 written instead, pend_o[9] clears.
5. LU push addr=0 -> handshake completes, FIFO count unchanged, pend_o unchanged, no write.
6. rst_n_i pulsed low mid-drain with 3 entries queued -> outputs zero immediately (asynchronous); after release FIFO empty, lu_ready_o=1, no stale writes.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// Merges the in-order MEM/WB result with buffered long-latency unit results
// into one registered register-file write per cycle. Publishes a bitmap of
// destinations still waiting in the buffer, and forces a drain when buffered
// results have waited too long.
module wb_port_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        pipe_valid_i,
    input  logic [4:0]  pipe_addr_i,
    input  logic [31:0] pipe_data_i,
    input  logic        lu_valid_i,
    output logic        lu_ready_o,
    input  logic [4:0]  lu_addr_i,
    input  logic [31:0] lu_data_i,
    output logic [4:0]  RDaddr_o,
    output logic [31:0] RDdata_o,
    output logic        RegWrite_o,
    output logic [31:0] pend_o,
    output logic        stall_o
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [4:0]        fifo_addr [DEPTH];
    logic [31:0]       fifo_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [WAIT_W-1:0] wait_cnt;
    logic [PTR_W-1:0]  pend_idx;

    logic fifo_empty;
    logic fifo_full;
    logic pipe_grant;
    logic push;
    logic pop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(DEPTH));

    // Ready comes from stored occupancy only, so a same-cycle pop never
    // opens room for a push; it is held low while reset is asserted.
    assign lu_ready_o = rst_n_i & ~fifo_full;

    assign stall_o = (wait_cnt == WAIT_W'(MAX_WAIT));

    // A forced drain outranks the pipe; register 0 results never win a grant.
    assign pipe_grant = ~stall_o & pipe_valid_i & (pipe_addr_i != 5'd0);
    assign pop        = ~fifo_empty & (stall_o | ~pipe_grant);
    assign push       = lu_valid_i & lu_ready_o & (lu_addr_i != 5'd0);

    // Buffer storage; contents are meaningful only inside the occupied window.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr[wr_ptr] <= lu_addr_i;
            fifo_data[wr_ptr] <= lu_data_i;
        end
    end

    // Circular-buffer pointers and occupancy; reset discards every entry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Starvation counter: counts cycles with buffered work but no drain.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_cnt <= '0;
        end else if (fifo_empty || pop) begin
            wait_cnt <= '0;
        end else if (!stall_o) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Registered write port; address and data hold when nothing is granted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            RegWrite_o <= 1'b0;
            RDaddr_o   <= 5'd0;
            RDdata_o   <= 32'd0;
        end else if (pipe_grant) begin
            RegWrite_o <= 1'b1;
            RDaddr_o   <= pipe_addr_i;
            RDdata_o   <= pipe_data_i;
        end else if (pop) begin
            RegWrite_o <= 1'b1;
            RDaddr_o   <= fifo_addr[rd_ptr];
            RDdata_o   <= fifo_data[rd_ptr];
        end else begin
            RegWrite_o <= 1'b0;
        end
    end

    // Pending bitmap: one-hot destinations of every occupied buffer slot.
    always_comb begin
        pend_o   = '0;
        pend_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pend_idx = rd_ptr + PTR_W'(k);
            if (CNT_W'(k) < count) begin
                pend_o[fifo_addr[pend_idx]] = 1'b1;
            end
        end
        pend_o[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter.
// Stimulus is driven on falling edges; a queue-based reference model predicts
// each cycle's write, and a separate monitor compares it after each rising edge.
module tb_wb_port_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        pipe_valid_i;
    logic [4:0]  pipe_addr_i;
    logic [31:0] pipe_data_i;
    logic        lu_valid_i;
    logic        lu_ready_o;
    logic [4:0]  lu_addr_i;
    logic [31:0] lu_data_i;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;
    logic        RegWrite_o;
    logic [31:0] pend_o;
    logic        stall_o;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    wr_t  exp_q[$];
    ent_t model_q[$];
    int   model_wait = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;

    wb_port_arbiter #(
        .DEPTH(DEPTH),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .pipe_valid_i(pipe_valid_i),
        .pipe_addr_i(pipe_addr_i),
        .pipe_data_i(pipe_data_i),
        .lu_valid_i(lu_valid_i),
        .lu_ready_o(lu_ready_o),
        .lu_addr_i(lu_addr_i),
        .lu_data_i(lu_data_i),
        .RDaddr_o(RDaddr_o),
        .RDdata_o(RDdata_o),
        .RegWrite_o(RegWrite_o),
        .pend_o(pend_o),
        .stall_o(stall_o)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] modelPend();
        logic [31:0] p;
        p = 32'd0;
        foreach (model_q[i]) p = p | (32'd1 << model_q[i].addr);
        return p;
    endfunction

    // Drive one cycle of inputs, check state-derived outputs, and predict the grant.
    task automatic applyStimulus(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                                 input logic lv, input logic [4:0] la, input logic [31:0] ld);
        bit   m_stall;
        bit   m_ready;
        bit   was_empty;
        bit   popped;
        ent_t head;
        wr_t  w;
        @(negedge clk_i);
        pipe_valid_i = pv;
        pipe_addr_i  = pa;
        pipe_data_i  = pd;
        lu_valid_i   = lv;
        lu_addr_i    = la;
        lu_data_i    = ld;
        m_stall   = (model_wait == MAX_WAIT);
        m_ready   = (model_q.size() != DEPTH);
        was_empty = (model_q.size() == 0);
        checkOutput("lu_ready", 32'(lu_ready_o), 32'(m_ready));
        checkOutput("stall", 32'(stall_o), 32'(m_stall));
        checkOutput("pend", pend_o, modelPend());
        w = '0;
        popped = 1'b0;
        if (m_stall && !was_empty) begin
            head = model_q.pop_front();
            w = {1'b1, head.addr, head.data};
            popped = 1'b1;
        end else if (pv && pa != 5'd0) begin
            w = {1'b1, pa, pd};
        end else if (!was_empty) begin
            head = model_q.pop_front();
            w = {1'b1, head.addr, head.data};
            popped = 1'b1;
        end
        if (was_empty || popped) model_wait = 0;
        else if (model_wait < MAX_WAIT) model_wait++;
        if (lv && m_ready && la != 5'd0) model_q.push_back({la, ld});
        exp_q.push_back(w);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic checkResetOutputs(input bit ready_req);
        checkOutput("rst_regwrite", 32'(RegWrite_o), 32'd0);
        checkOutput("rst_rdaddr", 32'(RDaddr_o), 32'd0);
        checkOutput("rst_rddata", RDdata_o, 32'd0);
        checkOutput("rst_pend", pend_o, 32'd0);
        checkOutput("rst_stall", 32'(stall_o), 32'd0);
        checkOutput("rst_ready", 32'(lu_ready_o), 32'(ready_req));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulseReset();
        @(negedge clk_i);
        pipe_valid_i = 1'b0;
        lu_valid_i   = 1'b0;
        #2 rst_n_i = 1'b0;
        #1 checkResetOutputs(1'b0);
        model_q.delete();
        exp_q.delete();
        model_wait = 0;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1 checkResetOutputs(1'b1);
    endtask

    // Scoreboard monitor: after each rising edge, compare the write against the prediction.
    initial begin
        wr_t w;
        forever begin
            @(posedge clk_i);
            #2;
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                checkOutput("regwrite", 32'(RegWrite_o), 32'(w.we));
                if (w.we) begin
                    checkOutput("rdaddr", 32'(RDaddr_o), 32'(w.addr));
                    checkOutput("rddata", RDdata_o, w.data);
                end
            end
        end
    end

    // Main stimulus sequence: directed scenarios followed by randomized traffic.
    initial begin
        pipe_valid_i = 1'b0;
        pipe_addr_i  = 5'd0;
        pipe_data_i  = 32'd0;
        lu_valid_i   = 1'b0;
        lu_addr_i    = 5'd0;
        lu_data_i    = 32'd0;
        rst_n_i      = 1'b1;
        #1 rst_n_i = 1'b0;
        #1 checkResetOutputs(1'b0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        #1 checkResetOutputs(1'b1);

        $display("[TB] pipe write to r5");
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        idle(2);

        $display("[TB] long-latency write to r7");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678);
        idle(3);

        $display("[TB] pipe saturation with buffer fill and forced drain");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 5'd3, $urandom, (i < 14), (i < 4) ? 5'(8 + i) : 5'd12, $urandom);
        end
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 5'd3, $urandom, 1'b0, 5'd0, 32'd0);
        idle(8);

        $display("[TB] pipe to r0 while r9 is buffered");
        applyStimulus(1'b1, 5'd3, $urandom, 1'b1, 5'd9, 32'h99999999);
        applyStimulus(1'b1, 5'd0, 32'hBAD0BAD0, 1'b0, 5'd0, 32'd0);
        idle(2);

        $display("[TB] long-latency push to r0");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hCAFEF00D);
        idle(2);

        $display("[TB] reset mid-drain");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'd4, $urandom, 1'b1, 5'(20 + i), $urandom);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        pulseReset();
        idle(4);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            int pv_pct;
            pv_pct = (i < 300) ? 9 : 4;
            if (i == 450) pulseReset();
            applyStimulus($urandom_range(0, 9) < pv_pct, 5'($urandom_range(0, 31)), $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        end
        idle(12);
        @(negedge clk_i);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
